// File: rtl/result_piso_tx.sv
// rtl/result_piso_tx.sv - serial return path for voted TMR ALU results with even parity
module result_piso_tx #(
    parameter int FRAME_W = 32,
    parameter int CLK_DIV = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] RES_ALU,
    input  logic [14:0] RES_MUL,
    input  logic        RES_COUT,
    input  logic        LOAD_REQ,
    output logic        LOAD_ACK,
    output logic        DATA_OUT,
    output logic        DATA_VALID,
    output logic        TX_BUSY,
    output logic        TX_DONE
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [5:0] BIT_LAST = 6'(FRAME_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY,
        DONE
    } state_t;

    state_t               state;
    logic [FRAME_W-1:0]   shift_reg;
    logic                 parity_bit;
    logic [5:0]           bit_cnt;
    logic [7:0]           div_cnt;
    logic                 ack_q;
    logic                 valid_q;
    logic                 busy_q;
    logic                 done_q;
    logic [FRAME_W-1:0]   frame_word;

    // Frame ordering puts the ALU result in the low bits so it leaves the chip first.
    assign frame_word = FRAME_W'({RES_COUT, RES_MUL, RES_ALU});

    // The serial line is the low bit of the shift register; the parity bit is
    // parked there during its period so DATA_OUT stays a plain flop output.
    assign DATA_OUT   = shift_reg[0];
    assign LOAD_ACK   = ack_q;
    assign DATA_VALID = valid_q;
    assign TX_BUSY    = busy_q;
    assign TX_DONE    = done_q;

    // Frame sequencer: capture, per-bit hold by the divider, parity, done pulse.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            ack_q      <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            ack_q  <= 1'b0;
            done_q <= 1'b0;
            case (state)
                // DONE shares the capture path so a held request restarts with a one-cycle gap.
                IDLE, DONE: begin
                    if (LOAD_REQ) begin
                        shift_reg  <= frame_word;
                        parity_bit <= ^frame_word;
                        bit_cnt    <= '0;
                        div_cnt    <= '0;
                        ack_q      <= 1'b1;
                        valid_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        state      <= SHIFT;
                    end else begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            shift_reg <= {{(FRAME_W-1){1'b0}}, parity_bit};
                            state     <= PARITY;
                        end else begin
                            bit_cnt   <= bit_cnt + 6'd1;
                            shift_reg <= {1'b0, shift_reg[FRAME_W-1:1]};
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                PARITY: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt   <= '0;
                        shift_reg <= '0;
                        valid_q   <= 1'b0;
                        done_q    <= 1'b1;
                        state     <= DONE;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_piso_tx.sv
// tb/tb_result_piso_tx.sv - randomized and directed bench for result_piso_tx against a timeline model
module tb_result_piso_tx;

    logic        CLK;
    logic        RST;
    logic [15:0] RES_ALU;
    logic [14:0] RES_MUL;
    logic        RES_COUT;
    logic        LOAD_REQ;

    logic ack1, data1, valid1, busy1, done1;
    logic ack4, data4, valid4, busy4, done4;
    logic [4:0] o1, o4;

    int total = 0;
    int bad   = 0;

    result_piso_tx #(.FRAME_W(32), .CLK_DIV(1)) u1 (
        .CLK(CLK), .RST(RST), .RES_ALU(RES_ALU), .RES_MUL(RES_MUL), .RES_COUT(RES_COUT),
        .LOAD_REQ(LOAD_REQ), .LOAD_ACK(ack1), .DATA_OUT(data1), .DATA_VALID(valid1),
        .TX_BUSY(busy1), .TX_DONE(done1)
    );

    result_piso_tx #(.FRAME_W(32), .CLK_DIV(4)) u4 (
        .CLK(CLK), .RST(RST), .RES_ALU(RES_ALU), .RES_MUL(RES_MUL), .RES_COUT(RES_COUT),
        .LOAD_REQ(LOAD_REQ), .LOAD_ACK(ack4), .DATA_OUT(data4), .DATA_VALID(valid4),
        .TX_BUSY(busy4), .TX_DONE(done4)
    );

    assign o1 = {ack1, valid1, data1, busy1, done1};
    assign o4 = {ack4, valid4, data4, busy4, done4};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Model: each DUT is either idle or at cycle t of a frame timeline.
    bit        m_active [2];
    int        m_t      [2];
    bit [31:0] m_word   [2];
    bit        m_par    [2];

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic logic [4:0] model_out(input int i);
        int   len;
        int   idx;
        logic a, v, d, b, dn;
        len = 33 * div_of(i);
        a = 0; v = 0; d = 0; b = 0; dn = 0;
        if (m_active[i]) begin
            b  = 1;
            a  = (m_t[i] == 0);
            v  = (m_t[i] < len);
            dn = (m_t[i] == len);
            if (v) begin
                idx = m_t[i] / div_of(i);
                d = (idx < 32) ? m_word[i][idx] : m_par[i];
            end
        end
        return {a, v, d, b, dn};
    endfunction

    always @(negedge RST) begin
        for (int i = 0; i < 2; i++) m_active[i] = 0;
    end

    always @(posedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (!RST) begin
                m_active[i] = 0;
            end else if (!m_active[i] || m_t[i] == 33 * div_of(i)) begin
                if (LOAD_REQ) begin
                    m_active[i] = 1;
                    m_t[i]      = 0;
                    m_word[i]   = {RES_COUT, RES_MUL, RES_ALU};
                    m_par[i]    = ^{RES_COUT, RES_MUL, RES_ALU};
                end else begin
                    m_active[i] = 0;
                end
            end else begin
                m_t[i] = m_t[i] + 1;
            end
        end
    end

    // Every-cycle comparison of both DUTs against the model, away from the active edge.
    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            logic [4:0] got, exp;
            got = (i == 0) ? o1 : o4;
            exp = model_out(i);
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL cycle_cmp dut_div%0d t=%0t got{ack,vld,dat,busy,done}=%b exp=%b",
                         div_of(i), $time, got, exp);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Gathers one frame from a DUT, starting with the cycle after the capture edge.
    task automatic collect(input int which, input int maxc, output logic [31:0] word,
                           output logic par, output int nvalid, output int nbusy,
                           output int done_at, output int nack);
        logic [4:0] o;
        int idx;
        word = '0; par = 0; nvalid = 0; nbusy = 0; done_at = -1; nack = 0;
        for (int c = 0; c < maxc; c++) begin
            @(negedge CLK);
            o = (which == 0) ? o1 : o4;
            if (o[4]) nack++;
            if (o[3]) begin
                idx = nvalid / div_of(which);
                if (idx < 32) word[idx] = o[2];
                else par = o[2];
                nvalid++;
            end
            if (o[1]) nbusy++;
            if (o[0]) begin
                done_at = c;
                break;
            end
        end
        if (done_at < 0) chk("collect_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        int c;
        for (c = 0; c < 400; c++) begin
            @(negedge CLK);
            if (!busy1 && !busy4) break;
        end
        if (c == 400) chk("wait_idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic set_frame(input logic [31:0] f);
        {RES_COUT, RES_MUL, RES_ALU} = f;
    endtask

    initial begin
        logic [31:0] w;
        logic        p;
        int nv, nb, da, na;

        RST = 0; LOAD_REQ = 0; RES_ALU = '0; RES_MUL = '0; RES_COUT = 0;
        repeat (3) @(negedge CLK);
        chk("reset_state_div1", {59'd0, o1}, 64'd0);
        chk("reset_state_div4", {59'd0, o4}, 64'd0);
        #1 RST = 1;
        @(negedge CLK);

        // Test 1: 32'h9234ABCD, CLK_DIV=1
        #1 RES_COUT = 1; RES_MUL = 15'h1234; RES_ALU = 16'hABCD; LOAD_REQ = 1;
        fork
            collect(0, 60, w, p, nv, nb, da, na);
            begin @(negedge CLK); #1 LOAD_REQ = 0; end
        join
        chk("t1_word", w, 64'h9234ABCD);
        chk("t1_parity", p, 0);
        chk("t1_valid_cycles", nv, 33);
        chk("t1_busy_cycles", nb, 34);
        chk("t1_done_at", da, 33);
        chk("t1_ack_count", na, 1);
        wait_idle();

        // Test 2: single set bit, CLK_DIV=4
        #1 set_frame(32'h0000_0001); LOAD_REQ = 1;
        fork
            collect(1, 200, w, p, nv, nb, da, na);
            begin @(negedge CLK); #1 LOAD_REQ = 0; end
        join
        chk("t2_word", w, 64'h1);
        chk("t2_parity", p, 1);
        chk("t2_valid_cycles", nv, 132);
        chk("t2_done_at", da, 132);
        wait_idle();

        // Test 3: request mid-frame with new data is ignored
        #1 set_frame(32'hC3A5_0F17); LOAD_REQ = 1;
        fork
            collect(0, 60, w, p, nv, nb, da, na);
            begin
                @(negedge CLK); #1 LOAD_REQ = 0;
                repeat (10) @(negedge CLK);
                #1 set_frame(32'h1111_2222); LOAD_REQ = 1;
                @(negedge CLK); #1 LOAD_REQ = 0;
            end
        join
        chk("t3_word", w, 64'hC3A50F17);
        chk("t3_ack_count", na, 1);
        wait_idle();
        repeat (5) @(negedge CLK);

        // Test 4: held request, back-to-back frames with one gap cycle
        #1 set_frame(32'hFFFF_FFFF); LOAD_REQ = 1;
        collect(0, 60, w, p, nv, nb, da, na);
        chk("t4_word", w, 64'hFFFFFFFF);
        chk("t4_parity", p, 0);
        @(negedge CLK);
        chk("t4_restart_ack_valid", {62'd0, ack1, valid1}, 64'd3);
        #1 LOAD_REQ = 0;
        wait_idle();

        // Test 5: asynchronous reset at bit 10
        #1 set_frame(32'h0F0F_1234); LOAD_REQ = 1;
        @(negedge CLK); #1 LOAD_REQ = 0;
        repeat (10) @(negedge CLK);
        @(posedge CLK); #2 RST = 0; #1;
        chk("t5_async_zero_div1", {59'd0, o1}, 64'd0);
        chk("t5_async_zero_div4", {59'd0, o4}, 64'd0);
        repeat (3) @(negedge CLK);
        #1 RST = 1;
        @(negedge CLK);
        #1 set_frame(32'hDEAD_0BEE); LOAD_REQ = 1;
        fork
            collect(0, 60, w, p, nv, nb, da, na);
            begin @(negedge CLK); #1 LOAD_REQ = 0; end
        join
        chk("t5_fresh_word", w, 64'hDEAD0BEE);
        chk("t5_fresh_valid_cycles", nv, 33);
        wait_idle();

        // Test 6: inputs churn during transmission
        #1 set_frame(32'h5555_AAAA); LOAD_REQ = 1;
        fork
            collect(0, 60, w, p, nv, nb, da, na);
            begin
                @(negedge CLK); #1 LOAD_REQ = 0;
                repeat (40) begin
                    set_frame($urandom);
                    @(negedge CLK); #1;
                end
            end
        join
        chk("t6_word", w, 64'h5555AAAA);
        chk("t6_parity", p, 0);
        wait_idle();

        // Random phase: sparse/held requests, churning data, occasional async resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK); #1;
            set_frame($urandom);
            if ($urandom_range(0, 3) == 0) LOAD_REQ = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 399) == 0) begin
                #2 RST = 0;
                repeat ($urandom_range(1, 2)) @(negedge CLK);
                #1 RST = 1;
            end
        end
        #1 LOAD_REQ = 0;
        wait_idle();
        repeat (3) @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/result_piso_tx.md
Name: result_piso_tx

Overview:
Parallel-in/serial-out transmitter that returns voted TMR ALU results off-chip over the same 1-bit data plus qualifier scheme used on the inbound SIPO path.
- Captures one result frame {COUT, OUT_2[14:0], OUT[15:0]} and shifts it out LSB first, followed by an even-parity bit.
- Sits downstream of the voter stage in the TMR ALU top level.
- Is the return-direction counterpart of the inbound serial loader.

Parameters:
FRAME_W, 32, payload bits per frame (16 ALU + 15 MUL + 1 COUT).
CLK_DIV, 1, CLK cycles each serial bit is held (1..255).

Ports:
CLK  input  1  system clock, rising edge.
RST  input  1  asynchronous, active-low reset.
RES_ALU  input  16  voted ALU result (OUT).
RES_MUL  input  15  voted multiplier result (OUT_2).
RES_COUT  input  1  voted carry out.
LOAD_REQ  input  1  request to transmit current result; level-sampled each cycle.
LOAD_ACK  output  1  one-cycle pulse: frame captured.
DATA_OUT  output  1  serial data.
DATA_VALID  output  1  high while DATA_OUT carries a frame bit (payload or parity).
TX_BUSY  output  1  high from capture until frame complete.
TX_DONE  output  1  one-cycle pulse after the parity bit period ends.

Behaviour:
- Reset (RST=0, async, overrides everything including mid-frame):
  - State=IDLE; shift register, bit counter and divider counter cleared.
  - LOAD_ACK=0, DATA_OUT=0, DATA_VALID=0, TX_BUSY=0, TX_DONE=0.
  - A frame in progress is abandoned; no TX_DONE is issued for it.
- Release from reset is synchronous to the next CLK edge.
- Frame word: F = {RES_COUT, RES_MUL, RES_ALU}; bit0 = RES_ALU[0], bit31 = RES_COUT.
- Parity bit P = XOR of F[31:0], i.e. even parity over payload plus P.
- States:
  - IDLE: outputs low. If LOAD_REQ=1 at edge k: capture F and P, pulse LOAD_ACK for the cycle after edge k, set TX_BUSY, go to SHIFT.
  - SHIFT: from edge k onward DATA_VALID=1 and DATA_OUT=F[0]. Each bit is held exactly CLK_DIV cycles, then the register shifts right. After bit FRAME_W-1 has been held CLK_DIV cycles, go to PARITY.
  - PARITY: DATA_OUT=P, DATA_VALID=1 for CLK_DIV cycles, then go to DONE.
  - DONE: one cycle. DATA_VALID=0, DATA_OUT=0, TX_DONE=1, TX_BUSY=1. Return to IDLE next edge.
- Frame length: (FRAME_W+1)*CLK_DIV cycles with DATA_VALID high, plus 1 DONE cycle.
- Earliest next capture is at the edge that leaves DONE, so back-to-back frames have a 1-cycle DATA_VALID gap.
- LOAD_REQ while TX_BUSY=1 is ignored: no ACK and no recapture. If the requester still holds LOAD_REQ in IDLE, it is accepted.
- Inputs RES_* are sampled only at the capture edge; later changes do not affect the frame in flight.
- Bit counter: 6 bits, counts 0..FRAME_W-1, no wrap beyond.
- Divider counter: counts 0..CLK_DIV-1, reloads at 0 for every bit including parity.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. RES_COUT=1, RES_MUL=15'h1234, RES_ALU=16'hABCD, CLK_DIV=1, LOAD_REQ pulse → LOAD_ACK 1 cycle; 32 DATA_VALID cycles serialising 32'h9234ABCD LSB first (1,0,1,1,0,0,1,1,...); parity bit 0; TX_DONE 1 cycle later; TX_BUSY high for 34 cycles.
2. F=32'h0000_0001, CLK_DIV=4 → each bit held 4 cycles; parity=1; DATA_VALID high 132 cycles; TX_DONE at cycle 133 after capture.
3. Second LOAD_REQ pulsed mid-frame with different RES_* values → no LOAD_ACK; transmitted bits unchanged; after TX_DONE, IDLE with no transmission.
4. LOAD_REQ held high continuously with F=32'hFFFF_FFFF → back-to-back frames, parity=0 each, exactly 1 DATA_VALID-low cycle (DONE) between frames.
5. Assert RST=0 asynchronously at bit 10 of a frame → all outputs 0 immediately without waiting for a clock edge; no TX_DONE; after release, a new LOAD_REQ transmits a fresh full frame from bit0.
6. RES_* changed every cycle during transmission of 32'h5555_AAAA → serial stream matches the captured value only; parity 0.
